display_scheduler: RTL and testbench
====================================

Name: display_scheduler

Overview:
- Owns the 4-digit seven-segment display. Scans the digits and decides what is shown.
- Content sources, in priority order:
  - end-of-game GOAL banner;
  - timed message overlay requested by game logic (match/miss/etc.);
  - default score readout of removed cards.
- Sits between game control and the board AN/C pins. Replaces free-running scan logic with one clock-enable-based scheduler.

Parameters:
- SCAN_DIV, 16, prescaler width; one scan tick every 2^SCAN_DIV clk cycles.
- HOLD_TICKS, 1024, scan ticks a message overlay stays on display (must be >= 1).
- NUM_PAIRS, 16, removed_cards value that means game complete.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- removed_cards  in  5  removed-card count (0..31)
- msg_req  in  1  request overlay; requester holds high until msg_ack
- msg_code  in  2  overlay select, sampled on the ack cycle
- msg_ack  out  1  one-cycle pulse when request accepted
- mode  out  2  current state: 0 SCORE, 1 MSG, 2 GOAL
- AN  out  4  digit anodes, active-low; AN[3] leftmost
- C  out  8  segments, active-low; C[7]=dp, C[6:0]=g..a

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values:
  - AN=4'b1111, C=8'hFF, msg_ack=0, mode=SCORE.
  - Prescaler, digit index, hold counter and blink counter all 0.
  - Reset asserted mid-MSG or mid-GOAL returns to SCORE on that edge; any pending request is dropped without ack.
- Scan tick:
  - SCAN_DIV-bit prescaler increments every cycle.
  - tick is a single-cycle enable when prescaler is all-ones. It is not used as a clock.
- Digit scan:
  - 2-bit index advances on tick.
  - index 0->AN=1110, 1->1101, 2->1011, 3->0111.
  - AN/C are registered and update on the cycle after tick (latency 1). Between ticks they hold.
- Glyphs (C values):
  - digits 0-9: C0,F9,A4,B0,99,92,82,F8,80,90.
  - G=C2, O=C0, A=88, L=C7, d=A1, b=83, P=8C, Y=91, E=86, r=AF, blank=FF.
- SCORE state:
  - AN[0] shows removed_cards%10; AN[1] shows removed_cards/10 (0..3), blanked when 0.
  - AN[3:2] blank.
  - Value is sampled on each tick.
- MSG state: shows a 4-char string left to right (AN[3]..AN[0]):
  - code 0 "GOOd"
  - code 1 "bAd "
  - code 2 "PLAY"
  - code 3 "Err "
- GOAL state: shows "GOAL".
- Transitions (evaluated every cycle):
  - SCORE -> GOAL when removed_cards==NUM_PAIRS. Takes priority over a simultaneous msg_req, which gets no ack.
  - SCORE -> MSG when msg_req=1: msg_ack=1 that cycle, msg_code latched, hold counter loaded with HOLD_TICKS.
  - MSG: hold counter decrements on tick. At the tick where it reaches 0, go to GOAL if removed_cards==NUM_PAIRS, else SCORE.
  - msg_req while in MSG or GOAL: ignored, no ack, request stays pending until SCORE.
  - GOAL -> SCORE when removed_cards!=NUM_PAIRS (new game). GOAL is otherwise sticky.
- mode reflects the registered state.

Optional Feature:
- DISPLAY_BLINK_EN
  - Defined: in GOAL, an 8-bit tick counter toggles a blink phase every 256 ticks; during the off phase AN=1111, C=FF. Blink counter clears on entry to GOAL.
  - Undefined: GOAL displays steadily and no blink counter exists.

Test Plan:
- Bench setup for all scenarios: SCAN_DIV=2, HOLD_TICKS=8, NUM_PAIRS=16.
- Reset and score: rst_n low 3 cycles -> AN=1111, C=FF. Release with removed_cards=7 -> over 4 ticks, AN=1110/C=F8, AN=1101/C=FF, 1011/FF, 0111/FF, each appearing 1 cycle after its tick.
- Two-digit score: removed_cards=12 -> AN=1110 shows A4, AN=1101 shows F9. Set to 5 -> tens digit blank.
- Message handshake: msg_req=1, code=1 in SCORE -> msg_ack pulses exactly 1 cycle and mode=1. Display shows 83,88,A1,FF on AN[3..0]. Returns to SCORE after 8 ticks. A second msg_req held during MSG gets its ack only after return to SCORE.
- Goal priority: removed_cards=16 and msg_req=1 on the same cycle -> mode=2, no ack, display C2,C0,88,C7. removed_cards=0 -> mode=0, then pending request acked.
- Reset mid-overlay: rst_n low during MSG tick 3 -> next edge mode=0, AN=1111, no ack. With DISPLAY_BLINK_EN, GOAL held 512 ticks -> outputs blank during ticks 256..511.

Source files
------------

// File: rtl/display_scheduler.sv
// Four-digit seven-segment scheduler: GOAL banner > timed message overlay > score readout.
// Optional `DISPLAY_BLINK_EN makes the GOAL banner blink every 256 scan ticks.
module display_scheduler #(
    parameter int SCAN_DIV   = 16,
    parameter int HOLD_TICKS = 1024,
    parameter int NUM_PAIRS  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] removed_cards,
    input  logic       msg_req,
    input  logic [1:0] msg_code,
    output logic       msg_ack,
    output logic [1:0] mode,
    output logic [3:0] AN,
    output logic [7:0] C
);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [7:0] BLANK = 8'hFF;

    typedef enum logic [1:0] {SCORE = 2'd0, MSG = 2'd1, GOAL = 2'd2} state_t;

    state_t        state;
    logic [SCAN_DIV-1:0] prescaler;
    logic [1:0]    digit;
    logic [HW-1:0] hold;
    logic [1:0]    code_q;
    logic          tick;
    logic          goal_hit;
    logic [3:0]    tens;
    logic [3:0]    ones;
    logic [31:0]   text;
    logic [3:0]    an_next;
    logic [7:0]    seg_next;
    logic          blink_off;

    assign tick     = &prescaler;
    assign goal_hit = (removed_cards == 5'(NUM_PAIRS));
    assign mode     = state;

    // Handshake: requester holds msg_req (and msg_code) until msg_ack; msg_ack is a
    // same-cycle pulse, only in SCORE, never while GOAL is due and never in reset.
    assign msg_ack = rst_n && (state == SCORE) && msg_req && !goal_hit;

    function automatic logic [7:0] dec(input logic [3:0] v);
        case (v)
            4'd0: dec = 8'hC0;
            4'd1: dec = 8'hF9;
            4'd2: dec = 8'hA4;
            4'd3: dec = 8'hB0;
            4'd4: dec = 8'h99;
            4'd5: dec = 8'h92;
            4'd6: dec = 8'h82;
            4'd7: dec = 8'hF8;
            4'd8: dec = 8'h80;
            4'd9: dec = 8'h90;
            default: dec = BLANK;
        endcase
    endfunction

    always_comb begin
        tens = 4'd0;
        ones = 4'(removed_cards);
        if (removed_cards >= 5'd30) begin
            tens = 4'd3;
            ones = 4'(removed_cards - 5'd30);
        end else if (removed_cards >= 5'd20) begin
            tens = 4'd2;
            ones = 4'(removed_cards - 5'd20);
        end else if (removed_cards >= 5'd10) begin
            tens = 4'd1;
            ones = 4'(removed_cards - 5'd10);
        end
    end

    // Strings are packed leftmost character (AN[3]) in the top byte.
    always_comb begin
        text = 32'hFFFF_FFFF;
        case (state)
            SCORE: text = {BLANK, BLANK, (tens == 4'd0) ? BLANK : dec(tens), dec(ones)};
            MSG: begin
                case (code_q)
                    2'd0:    text = 32'hC2C0_C0A1;
                    2'd1:    text = 32'h8388_A1FF;
                    2'd2:    text = 32'h8CC7_8891;
                    default: text = 32'h86AF_AFFF;
                endcase
            end
            GOAL:    text = 32'hC2C0_88C7;
            default: text = 32'hFFFF_FFFF;
        endcase
        an_next  = ~(4'b0001 << digit);
        seg_next = text[{digit, 3'b000} +: 8];
        if (blink_off) begin
            an_next  = 4'b1111;
            seg_next = BLANK;
        end
    end

`ifdef DISPLAY_BLINK_EN
    logic [7:0] blink_cnt;
    logic       blink_phase;

    always_ff @(posedge clk) begin
        if (!rst_n || state != GOAL) begin
            blink_cnt   <= 8'd0;
            blink_phase <= 1'b0;
        end else if (tick) begin
            blink_cnt <= blink_cnt + 8'd1;
            if (blink_cnt == 8'hFF) blink_phase <= ~blink_phase;
        end
    end

    assign blink_off = (state == GOAL) && blink_phase;
`else
    assign blink_off = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= SCORE;
            prescaler <= '0;
            digit     <= 2'd0;
            hold      <= '0;
            code_q    <= 2'd0;
            AN        <= 4'b1111;
            C         <= BLANK;
        end else begin
            prescaler <= prescaler + 1'b1;
            if (tick) begin
                digit <= digit + 2'd1;
                AN    <= an_next;
                C     <= seg_next;
            end
            case (state)
                SCORE: begin
                    if (goal_hit) begin
                        state <= GOAL;
                    end else if (msg_ack) begin
                        state  <= MSG;
                        code_q <= msg_code;
                        hold   <= HW'(HOLD_TICKS);
                    end
                end
                MSG: begin
                    if (tick) begin
                        hold <= hold - 1'b1;
                        if (hold == HW'(1)) state <= goal_hit ? GOAL : SCORE;
                    end
                end
                GOAL: begin
                    if (!goal_hit) state <= SCORE;
                end
                default: state <= SCORE;
            endcase
        end
    end
endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with SCAN_DIV=2, HOLD_TICKS=8, NUM_PAIRS=16.
// Ticks fall on every 4th clock edge after reset release (counted by ecnt).
module tb_display_scheduler;
    typedef struct {
        logic [4:0] removed;
        logic [3:0] an;
        logic [7:0] c;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] removed_cards = 5'd0;
    logic       msg_req = 1'b0;
    logic [1:0] msg_code = 2'd0;
    logic       msg_ack;
    logic [1:0] mode;
    logic [3:0] AN;
    logic [7:0] C;

    int checks = 0;
    int errors = 0;
    int ecnt = 0;
    logic [11:0] exp_q[$];
    logic [7:0]  str_tab[5][4];
    vec_t        vecs[22];

    always #5 clk = ~clk;

    display_scheduler #(.SCAN_DIV(2), .HOLD_TICKS(8), .NUM_PAIRS(16)) dut (
        .clk(clk), .rst_n(rst_n), .removed_cards(removed_cards),
        .msg_req(msg_req), .msg_code(msg_code), .msg_ack(msg_ack),
        .mode(mode), .AN(AN), .C(C)
    );

    task automatic step();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic to_tick();
        step();
        while (ecnt % 4 != 0) step();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    function automatic logic [3:0] an_of(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << d);
    endfunction

    // Queue the next four scan positions of string row `row`.
    task automatic push_str(input int row);
        for (int j = 0; j < 4; j++) begin
            int d;
            d = (ecnt / 4 + j) % 4;
            exp_q.push_back({an_of(d), str_tab[row][3-d]});
        end
    endtask

    task automatic check_ticks(input string name, input int n);
        for (int j = 0; j < n; j++) begin
            logic [11:0] e;
            to_tick();
            e = exp_q.pop_front();
            chk({name, "_an"}, 32'(AN), 32'(e[11:8]));
            chk({name, "_c"}, 32'(C), 32'(e[7:0]));
        end
    endtask

    initial begin
        int e0;
        int guard;
        logic early;

        str_tab = '{'{8'hC2, 8'hC0, 8'hC0, 8'hA1},
                    '{8'h83, 8'h88, 8'hA1, 8'hFF},
                    '{8'h8C, 8'hC7, 8'h88, 8'h91},
                    '{8'h86, 8'hAF, 8'hAF, 8'hFF},
                    '{8'hC2, 8'hC0, 8'h88, 8'hC7}};
        vecs[0]  = '{5'd7,  4'b1110, 8'hF8};
        vecs[1]  = '{5'd7,  4'b1101, 8'hFF};
        vecs[2]  = '{5'd7,  4'b1011, 8'hFF};
        vecs[3]  = '{5'd7,  4'b0111, 8'hFF};
        vecs[4]  = '{5'd12, 4'b1110, 8'hA4};
        vecs[5]  = '{5'd12, 4'b1101, 8'hF9};
        vecs[6]  = '{5'd12, 4'b1011, 8'hFF};
        vecs[7]  = '{5'd12, 4'b0111, 8'hFF};
        vecs[8]  = '{5'd5,  4'b1110, 8'h92};
        vecs[9]  = '{5'd5,  4'b1101, 8'hFF};
        vecs[10] = '{5'd31, 4'b1011, 8'hFF};
        vecs[11] = '{5'd31, 4'b0111, 8'hFF};
        vecs[12] = '{5'd31, 4'b1110, 8'hF9};
        vecs[13] = '{5'd31, 4'b1101, 8'hB0};
        vecs[14] = '{5'd20, 4'b1011, 8'hFF};
        vecs[15] = '{5'd20, 4'b0111, 8'hFF};
        vecs[16] = '{5'd20, 4'b1110, 8'hC0};
        vecs[17] = '{5'd20, 4'b1101, 8'hA4};
        vecs[18] = '{5'd10, 4'b1011, 8'hFF};
        vecs[19] = '{5'd10, 4'b0111, 8'hFF};
        vecs[20] = '{5'd10, 4'b1110, 8'hC0};
        vecs[21] = '{5'd10, 4'b1101, 8'hF9};

        // Reset
        for (int i = 0; i < 3; i++) step();
        chk("rst_an", 32'(AN), 32'hF);
        chk("rst_c", 32'(C), 32'hFF);
        chk("rst_ack", 32'(msg_ack), 32'h0);
        chk("rst_mode", 32'(mode), 32'h0);
        removed_cards = 5'd7;
        rst_n = 1'b1;
        ecnt = 0;

        // Score readout table, one vector per tick
        for (int i = 0; i < 22; i++) begin
            removed_cards = vecs[i].removed;
            to_tick();
            chk($sformatf("score%0d_an", i), 32'(AN), 32'(vecs[i].an));
            chk($sformatf("score%0d_c", i), 32'(C), 32'(vecs[i].c));
            chk($sformatf("score%0d_mode", i), 32'(mode), 32'h0);
        end
        step();
        chk("hold_an", 32'(AN), 32'(vecs[21].an));
        chk("hold_c", 32'(C), 32'(vecs[21].c));
        to_tick();

        // Message handshake and pending second request
        msg_code = 2'd1;
        msg_req  = 1'b1;
        #1;
        chk("ack_pulse", 32'(msg_ack), 32'h1);
        step();
        e0 = ecnt;
        chk("ack_drop", 32'(msg_ack), 32'h0);
        chk("msg_mode", 32'(mode), 32'h1);
        msg_req = 1'b0;
        push_str(1);
        check_ticks("bad", 4);
        msg_code = 2'd2;
        msg_req  = 1'b1;
        early = 1'b0;
        guard = 0;
        while (mode == 2'd1 && guard < 40) begin
            step();
            if (mode == 2'd1 && msg_ack) early = 1'b1;
            guard++;
        end
        chk("msg_len", 32'(ecnt - e0), 32'd31);
        chk("no_early_ack", 32'(early), 32'h0);
        chk("back_score", 32'(mode), 32'h0);
        chk("pending_ack", 32'(msg_ack), 32'h1);
        step();
        chk("msg2_mode", 32'(mode), 32'h1);
        msg_req = 1'b0;
        push_str(2);
        check_ticks("play", 4);
        guard = 0;
        while (mode != 2'd0 && guard < 40) begin
            step();
            guard++;
        end
        chk("msg2_end", 32'(mode), 32'h0);

        // GOAL takes priority over a simultaneous request
        removed_cards = 5'd16;
        msg_code = 2'd0;
        msg_req  = 1'b1;
        #1;
        chk("goal_noack", 32'(msg_ack), 32'h0);
        step();
        chk("goal_mode", 32'(mode), 32'h2);
        push_str(4);
        check_ticks("goal", 4);
        chk("goal_noack2", 32'(msg_ack), 32'h0);
        removed_cards = 5'd0;
        step();
        chk("newgame_mode", 32'(mode), 32'h0);
        chk("newgame_ack", 32'(msg_ack), 32'h1);
        step();
        chk("good_mode", 32'(mode), 32'h1);
        msg_req = 1'b0;
        push_str(0);
        check_ticks("good", 3);

        // Reset during the overlay
        msg_req = 1'b1;
        rst_n = 1'b0;
        step();
        chk("mrst_mode", 32'(mode), 32'h0);
        chk("mrst_an", 32'(AN), 32'hF);
        chk("mrst_c", 32'(C), 32'hFF);
        chk("mrst_ack", 32'(msg_ack), 32'h0);
        step();
        msg_req = 1'b0;
        exp_q.delete();

`ifdef DISPLAY_BLINK_EN
        removed_cards = 5'd16;
        rst_n = 1'b1;
        ecnt = 0;
        step();
        chk("blink_mode", 32'(mode), 32'h2);
        while (ecnt < 1024) step();
        chk("blink255_an", 32'(AN), 32'h7);
        chk("blink255_c", 32'(C), 32'hC2);
        while (ecnt < 1028) step();
        chk("blink256_an", 32'(AN), 32'hF);
        chk("blink256_c", 32'(C), 32'hFF);
        while (ecnt < 2048) step();
        chk("blink511_an", 32'(AN), 32'hF);
        chk("blink511_c", 32'(C), 32'hFF);
        while (ecnt < 2052) step();
        chk("blink512_an", 32'(AN), 32'hE);
        chk("blink512_c", 32'(C), 32'hC7);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
